combined_memory_hs: RTL
=======================

# combined_memory_hs

Parametrised A/D register pair with a handshaked data-RAM port for the nandgame CPU. It replaces the single-cycle, zero-latency `*A` access with a req/ack memory interface that may take any number of cycles. The block stalls the CPU until a `*A` read operand is available or a posted write has been accepted. It sits between the ALU result bus (`dat_x`) and the external data RAM/bus fabric.

## Interface
- `WIDTH`, 16, data width of A, D, `dat_x` and RAM data.
- `ADDR_W`, 16, RAM address width; must be ≤ `WIDTH`. `ram_addr` is the low `ADDR_W` bits of A.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `a_we`  in  1  write `dat_x` to A on commit.
- `d_we`  in  1  write `dat_x` to D on commit.
- `dref_we`  in  1  write `dat_x` to RAM[A] on commit.
- `dref_rd`  in  1  current instruction uses `*A` as an operand.
- `dat_x`  in  `WIDTH`  ALU result.
- `dat_a`, `dat_d`  out  `WIDTH`  current A and D.
- `dat_dref_a`  out  `WIDTH`  buffered RAM[A] read data.
- `stall`  out  1  CPU must hold its instruction (and PC) this cycle.
- `ram_req`  out  1  RAM transfer request.
- `ram_we`  out  1  1 = write, 0 = read.
- `ram_addr`  out  `ADDR_W`  RAM address.
- `ram_wdata`  out  `WIDTH`  RAM write data.
- `ram_ack`  in  1  RAM accepts/completes the request this cycle.
- `ram_rdata`  in  `WIDTH`  read data; valid when `ram_ack`=1 on a read.

## Operation
- **FSM states:** IDLE, RD, WR.
- **Stall rule:** `stall` = (state≠IDLE) | (IDLE & `dref_rd` & !`rd_valid`). The signal is combinational.
- **Commit:** an instruction commits in a cycle where state=IDLE and `stall`=0. Only at commit do `a_we`, `d_we` and `dref_we` take effect.
- **A/D update:** A and D are updated from `dat_x` on commit.
- **Write, same-instruction A update:** the write address is the pre-update A, even when the same instruction also writes A.
- **Read start:** in IDLE, `dref_rd`=1 with `rd_valid`=0 → RD.
- **Read transfer (RD):** `ram_req`=1, `ram_we`=0, `ram_addr`=A.
- **Read completion:** on `ram_ack`, `rbuf` ← `ram_rdata`, `rd_valid` ← 1, then → IDLE.
- **Read data path:** `dat_dref_a` = `rbuf` at all times.
- **Write capture:** a commit with `dref_we`=1 latches `waddr`←A[`ADDR_W`-1:0] and `wbuf`←`dat_x`, then → WR.
- **Write transfer (WR):** `ram_req`=1, `ram_we`=1, `ram_addr`=`waddr`, `ram_wdata`=`wbuf`. On `ram_ack` → IDLE.
- **Request hold:** `ram_req`, `ram_we`, `ram_addr` and `ram_wdata` stay stable from assertion until `ram_ack`. `ram_ack` is ignored when `ram_req`=0.
- **IDLE RAM outputs:** `ram_req`=0, `ram_we`=0, `ram_addr`=A, `ram_wdata`=0.
- **`rd_valid` clear:** cleared on any commit, so each instruction fetches `*A` fresh.
- **Read-modify-write:** `dref_rd` and `dref_we` in the same instruction run as RD, then commit, then WR. The write uses the address read from.

## Timing
- **Reset values:** A=0, D=0, `rbuf`=0, `rd_valid`=0, state=IDLE, `ram_req`=0, `ram_we`=0, `ram_wdata`=0, `ram_addr`=0. After reset `stall` follows `dref_rd`.
- **Reset mid-transfer:** abandons the transfer. `ram_req` drops at the next edge and no data is captured.
- **Read latency:** minimum 2 stall cycles for `*A` reads when ack arrives in the first RD cycle.
  - cycle 0: IDLE, stall.
  - cycle 1: RD, req + ack.
  - cycle 2: commit.
- **Read with ack latency N:** N-1 ack wait cycles add N-1 stall cycles.
- **Write latency:** the write is posted. The writing instruction commits in 0 stall cycles. The next instruction stalls for every WR cycle, minimum 1.
- **Back-to-back writes:** the second commits the cycle after the first's ack.

## Configuration
- `COMBINED_MEMORY_AUTOINC_EN`
  - **Defined:** adds input `a_inc` (1 bit). On commit with `a_inc`=1 and `a_we`=0, A ← A+1, wrapping modulo 2^`WIDTH`. `a_we` has priority over `a_inc`. A `dref_we` in the same instruction uses the pre-increment address.
  - **Undefined:** port absent; A changes only via `a_we`.

## Test plan
- **Reset:** assert `rst_n`=0 for 2 cycles with `dat_x`=16'hFFFF and all enables high → A=0, D=0, `dat_dref_a`=0, `ram_req`=0.
- **Write/read round trip:** A←16'h0010, then `dref_we` with `dat_x`=16'hBEEF, RAM acking after 3 cycles → `ram_req` high 3 cycles, `ram_we`=1, `ram_addr`=16'h0010, `ram_wdata`=16'hBEEF. A following `dref_rd` returns `dat_dref_a`=16'hBEEF after ack.
- **Simultaneous A update and write:** A=5, same instruction `a_we`=`dref_we`=1 with `dat_x`=9 → write to address 5 with data 9; A=9 afterwards.
- **Read-modify-write:** RAM[7]=3, A=7, `dref_rd`+`dref_we` with the ALU computing `*A`+1 → RD then WR. RAM[7]=4; `stall` high during both phases except the commit cycle.
- **Reset mid-RD:** `rst_n`=0 while waiting for ack → state IDLE, `ram_req`=0 next cycle, `rd_valid`=0, no `rbuf` update.
- **Autoinc (`COMBINED_MEMORY_AUTOINC_EN`):** A=16'hFFFF with `a_inc` → A=0. `a_inc`+`a_we` with `dat_x`=4 → A=4.

Source files
------------

// File: rtl/combined_memory_hs.sv
// A/D register pair for the nandgame CPU with a req/ack data-RAM port that stalls the CPU.
// Optional A auto-increment input a_inc_i is enabled by defining COMBINED_MEMORY_AUTOINC_EN.
module combined_memory_hs #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef COMBINED_MEMORY_AUTOINC_EN
  input  logic              a_inc_i,
`endif
  input  logic              a_we_i,
  input  logic              d_we_i,
  input  logic              dref_we_i,
  input  logic              dref_rd_i,
  input  logic [WIDTH-1:0]  dat_x_i,
  output logic [WIDTH-1:0]  dat_a_o,
  output logic [WIDTH-1:0]  dat_d_o,
  output logic [WIDTH-1:0]  dat_dref_a_o,
  output logic              stall_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [WIDTH-1:0]  ram_wdata_o,
  input  logic              ram_ack_i,
  input  logic [WIDTH-1:0]  ram_rdata_i,
  output logic [1:0]        dbg_state_o
);

  // RAM handshake: ram_req_o/ram_we_o/ram_addr_o/ram_wdata_o are held stable from the
  // first cycle of a request until the cycle in which ram_ack_i=1; a transfer completes
  // exactly in that cycle, and ram_ack_i is ignored whenever ram_req_o=0.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [WIDTH-1:0]  rbuf_q, rbuf_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]  wbuf_q, wbuf_d;

  assign stall_o      = (state_q != S_IDLE) | (dref_rd_i & ~rd_valid_q);
  assign dat_a_o      = a_q;
  assign dat_d_o      = d_q;
  assign dat_dref_a_o = rbuf_q;
  assign dbg_state_o  = state_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    d_d         = d_q;
    rbuf_d      = rbuf_q;
    rd_valid_d  = rd_valid_q;
    waddr_d     = waddr_q;
    wbuf_d      = wbuf_q;
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = a_q[ADDR_W-1:0];
    ram_wdata_o = '0;

    case (state_q)
      S_IDLE: begin
        if (dref_rd_i && !rd_valid_q) begin
          state_d = S_RD;
        end else begin
          // Commit: every register update uses the pre-commit A as the write address.
          rd_valid_d = 1'b0;
          if (a_we_i) begin
            a_d = dat_x_i;
          end
`ifdef COMBINED_MEMORY_AUTOINC_EN
          else if (a_inc_i) begin
            a_d = a_q + WIDTH'(1);
          end
`endif
          if (d_we_i) begin
            d_d = dat_x_i;
          end
          if (dref_we_i) begin
            waddr_d = a_q[ADDR_W-1:0];
            wbuf_d  = dat_x_i;
            state_d = S_WR;
          end
        end
      end

      S_RD: begin
        ram_req_o = 1'b1;
        if (ram_ack_i) begin
          rbuf_d     = ram_rdata_i;
          rd_valid_d = 1'b1;
          state_d    = S_IDLE;
        end
      end

      S_WR: begin
        ram_req_o   = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = waddr_q;
        ram_wdata_o = wbuf_q;
        if (ram_ack_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      d_q        <= '0;
      rbuf_q     <= '0;
      rd_valid_q <= 1'b0;
      waddr_q    <= '0;
      wbuf_q     <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      d_q        <= d_d;
      rbuf_q     <= rbuf_d;
      rd_valid_q <= rd_valid_d;
      waddr_q    <= waddr_d;
      wbuf_q     <= wbuf_d;
    end
  end

endmodule
